// File: rtl/adc_sched_pkg.sv
// adc_conv_scheduler shared definitions.
// Commands, channel index type, FSM states, peak width.
package adc_sched_pkg;

   localparam int PEAK_W = 14;
   localparam int N_CH   = 4;

   typedef logic [1:0] ch_idx_t;

   typedef enum logic [1:0] {
      CFG0,
      CFG1,
      RUN,
      IDLE
   } state_e;

   localparam logic [15:0] CMD_CFG0 = 16'hA000;
   localparam logic [15:0] CMD_CFG1 = 16'hAA00;

   localparam logic [15:0] CMD_CH [0:3] = '{
      16'h0000,
      16'h1000,
      16'h5000,
      16'h6000
   };

   // Lowest enabled channel strictly after cur, wrapping;
   // with one enabled channel the search lands back on it.
   function automatic ch_idx_t next_ch(
      input logic [N_CH-1:0] en,
      input ch_idx_t         cur
   );
      ch_idx_t idx;
      ch_idx_t res;
      logic    found;
      res   = cur;
      found = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         idx = cur + ch_idx_t'(k);
         if (!found && en[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/adc_conv_scheduler_timer.sv
// adc_frame_timer: gap/xfer frame counter for the ADC SPI frame.
// cs_n is registered; strobes decode the current count.
module adc_frame_timer #(
   parameter int unsigned GAP_CYC  = 51,
   parameter int unsigned XFER_CYC = 19
) (
   input  logic clk_1M,
   input  logic rst,
   input  logic clr_i,
   output logic cs_n_o,
   output logic eng_start_o,
   output logic frame_start_o,
   output logic capture_o
);

   localparam int unsigned FRM = GAP_CYC + XFER_CYC;
   localparam int unsigned CW  = $clog2(FRM);
   localparam logic [CW-1:0] LAST = CW'(FRM - 1);
   localparam logic [CW-1:0] XBEG = CW'(GAP_CYC);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          cs_n_q;
   logic          cs_n_d;

   // Next count wraps at frame end; clear restarts the gap.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr_i || cnt_q == LAST) begin
         cnt_d = '0;
      end
      cs_n_d = (cnt_d < XBEG);
   end

   // Count and chip-select registers.
   always_ff @(posedge clk_1M or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         cs_n_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         cs_n_q <= cs_n_d;
      end
   end

   assign cs_n_o        = cs_n_q;
   assign eng_start_o   = !cs_n_q;
   assign frame_start_o = (cnt_q == '0);
   assign capture_o     = (cnt_q == LAST);

endmodule

// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler: config frames, then round-robin conversions.
// Optional peak tracking: define ADC_PEAK_TRACK_EN.
module adc_conv_scheduler
   import adc_sched_pkg::*;
#(
   parameter int unsigned GAP_CYC    = 51,
   parameter int unsigned XFER_CYC   = 19,
   parameter int unsigned WIN_ROUNDS = 17857
) (
   input  logic        clk_1M,
   input  logic        rst,
   input  logic [3:0]  ch_en,
   input  logic        cfg_restart,
   output logic        eng_start,
   output logic [15:0] eng_cmd,
   input  logic [15:0] eng_rddat,
   input  logic        eng_done,
   output logic        cs_n,
   output logic        res_valid,
   output logic [1:0]  res_ch,
   output logic [15:0] res_data,
   output logic        busy,
   output logic        err_nodone,
   output logic        peak_valid,
   output logic [55:0] peak_bus
);

   state_e      state_q;
   state_e      state_d;
   logic        fs_raw;
   logic        cap_raw;
   logic        fs;
   logic        cap;
   logic        go_idle;
   logic        tmr_clr;
   logic        busy_d;
   ch_idx_t     sel;
   logic        wrap;
   logic        res_hit;
   logic        win_end;

   logic [15:0] cmd_q;
   ch_idx_t     cur_q;
   ch_idx_t     prv_q;
   logic        pend_q;
   logic        rv_q;
   ch_idx_t     rch_q;
   logic [15:0] rdat_q;
   logic        err_q;
   logic        seen_q;
   logic [15:0] round_q;

   adc_frame_timer #(
      .GAP_CYC  (GAP_CYC),
      .XFER_CYC (XFER_CYC)
   ) u_tmr (
      .clk_1M        (clk_1M),
      .rst           (rst),
      .clr_i         (tmr_clr),
      .cs_n_o        (cs_n),
      .eng_start_o   (eng_start),
      .frame_start_o (fs_raw),
      .capture_o     (cap_raw)
   );

   assign fs      = fs_raw && state_q != IDLE && !cfg_restart;
   assign cap     = cap_raw && !cfg_restart;
   assign go_idle = fs && state_q == RUN && ch_en == 4'b0;
   assign sel     = next_ch(ch_en, cur_q);
   assign wrap    = (sel <= cur_q);
   assign res_hit = cap && state_q == RUN && pend_q;
   assign win_end = res_hit && (round_q >= 16'(WIN_ROUNDS));

   // State register.
   always_ff @(posedge clk_1M or negedge rst) begin
      if (!rst) begin
         state_q <= CFG0;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: config frames advance at capture, restart wins.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CFG0: if (cap) state_d = CFG1;
         CFG1: if (cap) state_d = RUN;
         RUN:  if (go_idle) state_d = IDLE;
         IDLE: if (ch_en != 4'b0) state_d = RUN;
         default: state_d = CFG0;
      endcase
      if (cfg_restart) begin
         state_d = CFG0;
      end
   end

   // FSM outputs: IDLE parks the timer at a fresh gap.
   always_comb begin
      busy_d  = 1'b1;
      tmr_clr = cfg_restart || go_idle;
      if (state_q == IDLE) begin
         busy_d  = 1'b0;
         tmr_clr = 1'b1;
      end
   end

   assign busy = busy_d;

   // Command issue, one-frame result pipeline and done tracking.
   always_ff @(posedge clk_1M or negedge rst) begin
      if (!rst) begin
         cmd_q  <= '0;
         cur_q  <= ch_idx_t'(N_CH - 1);
         prv_q  <= '0;
         pend_q <= 1'b0;
         rv_q   <= 1'b0;
         rch_q  <= '0;
         rdat_q <= '0;
         err_q  <= 1'b0;
         seen_q <= 1'b0;
      end else begin
         rv_q <= 1'b0;
         if (cfg_restart) begin
            pend_q <= 1'b0;
            seen_q <= 1'b0;
         end else begin
            if (fs) begin
               seen_q <= eng_done;
               unique case (state_q)
                  CFG0: cmd_q <= CMD_CFG0;
                  CFG1: cmd_q <= CMD_CFG1;
                  RUN: begin
                     if (go_idle) begin
                        pend_q <= 1'b0;
                     end else begin
                        cmd_q <= CMD_CH[sel];
                        cur_q <= sel;
                     end
                  end
                  default: ;
               endcase
            end else begin
               seen_q <= seen_q || eng_done;
            end
            if (cap) begin
               if (!(seen_q || eng_done)) begin
                  err_q <= 1'b1;
               end
               if (state_q == RUN) begin
                  pend_q <= 1'b1;
                  prv_q  <= cur_q;
               end
            end
            if (res_hit) begin
               rv_q   <= 1'b1;
               rch_q  <= prv_q;
               rdat_q <= eng_rddat;
            end
         end
      end
   end

   // Round counter: a wrap after a real previous conversion ends a round.
   always_ff @(posedge clk_1M or negedge rst) begin
      if (!rst) begin
         round_q <= '0;
      end else if (win_end) begin
         round_q <= '0;
      end else if (fs && state_q == RUN && !go_idle && pend_q && wrap) begin
         round_q <= round_q + 16'd1;
      end
   end

   assign eng_cmd    = cmd_q;
   assign res_valid  = rv_q;
   assign res_ch     = rch_q;
   assign res_data   = rdat_q;
   assign err_nodone = err_q;

`ifdef ADC_PEAK_TRACK_EN

   logic [N_CH-1:0][PEAK_W-1:0] max_q;
   logic [N_CH-1:0][PEAK_W-1:0] peak_q;
   logic                        pv_q;
   logic [PEAK_W-1:0]           smp;

   assign smp = eng_rddat[15:2];

   // Per-channel running max; window end publishes and clears.
   always_ff @(posedge clk_1M or negedge rst) begin
      if (!rst) begin
         max_q  <= '0;
         peak_q <= '0;
         pv_q   <= 1'b0;
      end else begin
         pv_q <= 1'b0;
         if (res_hit) begin
            if (win_end) begin
               for (int i = 0; i < N_CH; i++) begin
                  if (ch_idx_t'(i) == prv_q && smp > max_q[i]) begin
                     peak_q[i] <= smp;
                  end else begin
                     peak_q[i] <= max_q[i];
                  end
               end
               max_q <= '0;
               pv_q  <= 1'b1;
            end else if (smp > max_q[prv_q]) begin
               max_q[prv_q] <= smp;
            end
         end
      end
   end

   assign peak_valid = pv_q;
   assign peak_bus   = peak_q;

`else

   assign peak_valid = 1'b0;
   assign peak_bus   = '0;

`endif

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Scoreboard bench for adc_conv_scheduler.
// Expected commands/results queued by stimulus, popped by the monitor.
module tb_adc_conv_scheduler;

   localparam int GAP  = 51;
   localparam int XFER = 19;
`ifdef ADC_PEAK_TRACK_EN
   localparam int WIN = 3;
`else
   localparam int WIN = 17857;
`endif

   logic        clk_1M = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  ch_en = 4'b0;
   logic        cfg_restart = 1'b0;
   logic [15:0] eng_rddat = 16'h0;
   logic        done_en = 1'b1;
   logic        eng_done;
   logic        eng_start;
   logic [15:0] eng_cmd;
   logic        cs_n;
   logic        res_valid;
   logic [1:0]  res_ch;
   logic [15:0] res_data;
   logic        busy;
   logic        err_nodone;
   logic        peak_valid;
   logic [55:0] peak_bus;

   assign eng_done = done_en & eng_start;

   always #5 clk_1M = ~clk_1M;

   adc_conv_scheduler #(
      .GAP_CYC    (GAP),
      .XFER_CYC   (XFER),
      .WIN_ROUNDS (WIN)
   ) dut (
      .clk_1M      (clk_1M),
      .rst         (rst),
      .ch_en       (ch_en),
      .cfg_restart (cfg_restart),
      .eng_start   (eng_start),
      .eng_cmd     (eng_cmd),
      .eng_rddat   (eng_rddat),
      .eng_done    (eng_done),
      .cs_n        (cs_n),
      .res_valid   (res_valid),
      .res_ch      (res_ch),
      .res_data    (res_data),
      .busy        (busy),
      .err_nodone  (err_nodone),
      .peak_valid  (peak_valid),
      .peak_bus    (peak_bus)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] cmd_q [$];
   logic [17:0] res_q [$];
   logic [13:0] pk_q [$];

`ifdef ADC_PEAK_TRACK_EN
   bit pk_on = 1'b0;
`else
   bit pk_on = 1'b1;
`endif

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic es_prev = 1'b0;
   int   cyc = 0;
   int   last_rise = 0;
   int   n_rise = 0;

   always @(negedge clk_1M) begin
      cyc++;
      if (eng_start && !es_prev) begin
         if (n_rise == 1 || n_rise == 2) begin
            chk("period", cyc - last_rise, GAP + XFER);
         end
         last_rise = cyc;
         n_rise++;
         if (cmd_q.size() == 0) begin
            chk("cmd_unexp", 32'(cmd_q.size()), 1);
         end else begin
            chk("cmd", 32'(eng_cmd), 32'(cmd_q.pop_front()));
         end
      end
      es_prev = eng_start;
      if (res_valid) begin
         if (res_q.size() == 0) begin
            chk("res_unexp", 32'(res_q.size()), 1);
         end else begin
            logic [17:0] e;
            e = res_q.pop_front();
            chk("res_ch", 32'(res_ch), 32'(e[17:16]));
            chk("res_data", 32'(res_data), 32'(e[15:0]));
         end
      end
      if (peak_valid && pk_on) begin
         if (pk_q.size() == 0) begin
            chk("pk_unexp", 32'(pk_q.size()), 1);
         end else begin
            chk("pk0", 32'(peak_bus[13:0]), 32'(pk_q.pop_front()));
            chk("pk_hi", 32'(|peak_bus[55:14]), 0);
         end
      end
   end

   task automatic wait_es(input logic v);
      bit ok = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge clk_1M);
         ok = (eng_start === v);
      end
      if (!ok) chk("tmo_es", 32'(eng_start), 32'(v));
   endtask

   task automatic wait_cmds();
      bit ok = 1'b0;
      for (int k = 0; k < 1500 && !ok; k++) begin
         @(negedge clk_1M);
         ok = (cmd_q.size() == 0);
      end
      if (!ok) chk("tmo_cmd", 32'(cmd_q.size()), 0);
   endtask

   task automatic wait_res();
      bit ok = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge clk_1M);
         ok = (res_q.size() == 0);
      end
      if (!ok) chk("tmo_res", 32'(res_q.size()), 0);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge clk_1M);
         ok = (busy === 1'b0);
      end
      if (!ok) chk("tmo_idle", 32'(busy), 0);
   endtask

   task automatic push_res(input logic [1:0] ch, input logic [15:0] d);
      res_q.push_back({ch, d});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk_1M);
      chk("rst_cs", 32'(cs_n), 1);
      chk("rst_es", 32'(eng_start), 0);
      chk("rst_cmd", 32'(eng_cmd), 0);
      chk("rst_rv", 32'(res_valid), 0);
      chk("rst_rch", 32'(res_ch), 0);
      chk("rst_rdat", 32'(res_data), 0);
      chk("rst_busy", 32'(busy), 1);
      chk("rst_err", 32'(err_nodone), 0);
      chk("rst_pv", 32'(peak_valid), 0);
      chk("rst_pk", 32'(|peak_bus), 0);

      // config frames, then all four channels
      ch_en     = 4'b1111;
      eng_rddat = 16'h1234;
      cmd_q = '{16'hA000, 16'hAA00, 16'h0000, 16'h1000,
                16'h5000, 16'h6000, 16'h0000};
      push_res(2'd0, 16'h1234);
      push_res(2'd1, 16'h1234);
      push_res(2'd2, 16'h1234);
      rst = 1'b1;
      wait_cmds();

      // sparse mask 1010
      ch_en     = 4'b1010;
      eng_rddat = 16'hBEEF;
      push_res(2'd3, 16'hBEEF);
      cmd_q = '{16'h1000, 16'h6000, 16'h1000, 16'h6000};
      push_res(2'd0, 16'hBEEF);
      push_res(2'd1, 16'hBEEF);
      push_res(2'd3, 16'hBEEF);
      wait_cmds();

      // mask drops mid-frame: frame completes, then IDLE
      ch_en = 4'b0000;
      push_res(2'd1, 16'hBEEF);
      wait_idle();
      repeat (10) @(negedge clk_1M);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_cs", 32'(cs_n), 1);
      chk("idle_es", 32'(eng_start), 0);

      // re-enable ch0: first frame has no result
      ch_en = 4'b0001;
      cmd_q = '{16'h0000, 16'h0000, 16'h0000};
      push_res(2'd0, 16'hBEEF);
      wait_es(1'b1);
      wait_es(1'b0);
      wait_es(1'b1);
      wait_es(1'b0);
      wait_es(1'b1);

      // restart at xfer cycle 5 of the third frame
      repeat (5) @(negedge clk_1M);
      eng_rddat   = 16'h5A5A;
      cfg_restart = 1'b1;
      cmd_q = '{16'hA000, 16'hAA00, 16'h0000, 16'h0000};
      push_res(2'd0, 16'h5A5A);
      @(negedge clk_1M);
      cfg_restart = 1'b0;
      chk("rs_cs", 32'(cs_n), 1);
      chk("rs_es", 32'(eng_start), 0);
      wait_cmds();
      chk("err0", 32'(err_nodone), 0);

      // one frame with no eng_done
      cmd_q = '{16'h0000, 16'h0000, 16'h0000};
      push_res(2'd0, 16'h5A5A);
      push_res(2'd0, 16'h5A5A);
      push_res(2'd0, 16'h5A5A);
      wait_es(1'b0);
      done_en = 1'b0;
      wait_es(1'b1);
      wait_es(1'b0);
      done_en = 1'b1;
      chk("err_set", 32'(err_nodone), 1);
      wait_es(1'b1);
      wait_es(1'b0);
      wait_es(1'b1);
      ch_en = 4'b0000;
      wait_idle();
      wait_res();
      chk("err_keep", 32'(err_nodone), 1);
      chk("cmd_left", 32'(cmd_q.size()), 0);
      chk("res_left", 32'(res_q.size()), 0);

`ifdef ADC_PEAK_TRACK_EN
      begin
         logic [15:0] tbl [0:8];
         bit ok;
         tbl = '{16'h0, 16'h0, 16'h0, 16'h0008, 16'hFFFC,
                 16'h0010, 16'h0004, 16'h0004, 16'h0004};
         @(negedge clk_1M);
         rst   = 1'b0;
         @(negedge clk_1M);
         ch_en = 4'b0001;
         cmd_q = '{16'hA000, 16'hAA00, 16'h0000, 16'h0000, 16'h0000,
                   16'h0000, 16'h0000, 16'h0000, 16'h0000};
         push_res(2'd0, 16'h0008);
         push_res(2'd0, 16'hFFFC);
         push_res(2'd0, 16'h0010);
         push_res(2'd0, 16'h0004);
         push_res(2'd0, 16'h0004);
         push_res(2'd0, 16'h0004);
         pk_q.push_back(14'h3FFF);
         pk_q.push_back(14'h0001);
         pk_on = 1'b1;
         rst   = 1'b1;
         for (int i = 0; i < 9; i++) begin
            wait_es(1'b1);
            eng_rddat = tbl[i];
            if (i == 8) ch_en = 4'b0000;
            wait_es(1'b0);
         end
         wait_idle();
         wait_res();
         ok = 1'b0;
         for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk_1M);
            ok = (pk_q.size() == 0);
         end
         chk("pk_left", 32'(pk_q.size()), 0);
      end
`else
      chk("pk_bus0", 32'(|peak_bus), 0);
      chk("pk_left", 32'(pk_q.size()), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
